rom_loader: RTL and testbench

Boot-time program loader for the Hack computer. Accepts a byte stream (length header followed by 16-bit instructions) over a valid/ready handshake and writes each word into instruction ROM at sequential addresses. While loading, it holds the CPU in reset so that the program counter starts fetching from address 0 only after the image is complete. It is the writer side of the instruction memory that the program counter reads.

---
 rtl/rom_loader.sv | 141 ++++++++++++++
 tb/tb_rom_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// Boot loader: length-prefixed byte stream -> sequential instruction ROM writes; holds CPU until image complete.
// 3 cycles/word best case (HI, LO, WRITE); byte_ready drops during WRITE/IDLE/DONE/ERR, byte_valid gaps stall.
module rom_loader #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] rom_data,
  output logic              rom_we,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t state, state_nxt;

  logic [7:0]        len_hi_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_hi_q;
  logic [DATA_W-1:0] word_q;

  logic [15:0]       len_word;
  logic              len_oversize;
  logic [ADDR_W:0]   cnt_inc;
  logic              last_word;
  logic              start_acc;

  assign len_word     = {len_hi_q, byte_in};
  // One extra bit so a header of exactly 2^ADDR_W words is accepted.
  assign len_oversize = {1'b0, len_word} > (17'd1 << ADDR_W);
  assign cnt_inc      = cnt_q + (ADDR_W + 1)'(1);
  assign last_word    = (cnt_inc == len_q);
  assign start_acc    = start && (state == S_IDLE || state == S_DONE || state == S_ERR);

  assign rom_addr = addr_q;
  assign rom_data = word_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    rom_we     = 1'b0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          if (len_word == 16'd0)  state_nxt = S_DONE;
          else if (len_oversize)  state_nxt = S_ERR;
          else                    state_nxt = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) state_nxt = S_DATA_LO;
      end
      S_DATA_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        rom_we    = 1'b1;
        state_nxt = last_word ? S_DONE : S_DATA_HI;
      end
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) state_nxt = S_LEN_HI;
      end
      S_ERR: begin
        error = 1'b1;
        if (start) state_nxt = S_LEN_HI;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      len_hi_q  <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_hi_q <= '0;
      word_q    <= '0;
    end else begin
      if (start_acc) begin
        addr_q <= '0;
        cnt_q  <= '0;
      end
      case (state)
        S_LEN_HI:  if (byte_valid) len_hi_q <= byte_in;
        // Only meaningful when the header is in range, which is the only way into DATA_HI.
        S_LEN_LO:  if (byte_valid) len_q <= len_word[ADDR_W:0];
        S_DATA_HI: if (byte_valid) data_hi_q <= byte_in;
        S_DATA_LO: if (byte_valid) word_q <= {data_hi_q, byte_in};
        S_WRITE: begin
          addr_q <= addr_q + ADDR_W'(1);
          cnt_q  <= cnt_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: expected ROM writes queued as stimulus is driven, checked as rom_we fires.
module tb_rom_loader;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;

  logic              clk;
  logic              reset;
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              rom_we;
  logic              cpu_hold;
  logic              done;
  logic              error;

  rom_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rom_we     (rom_we),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  int we_cycles[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && rom_we === 1'b1) begin
      logic [ADDR_W+DATA_W-1:0] e;
      we_cycles.push_back(cyc);
      check("we_ready_low", byte_ready, 0);
      check("we_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("we_addr", rom_addr, e[ADDR_W+DATA_W-1:DATA_W]);
        check("we_data", rom_data, e[DATA_W-1:0]);
      end
    end
  end

  task automatic expect_word(input int addr, input logic [15:0] data);
    exp_q.push_back({ADDR_W'(addr), data});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_ready", byte_ready, 1);
  endtask

  // Idles byte_valid for `gap` cycles, then offers the byte until it transfers.
  task automatic send(input logic [7:0] b, input int gap);
    int k;
    byte_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    byte_valid = 1'b1;
    byte_in    = b;
    k = 0;
    @(negedge clk);
    while (byte_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("byte_ready_wait", byte_ready, 1);
    if (byte_ready === 1'b1) begin
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_byte_ready"}, byte_ready, 0);
    check({tag, "_rom_we"},     rom_we,     0);
    check({tag, "_rom_addr"},   rom_addr,   0);
    check({tag, "_cpu_hold"},   cpu_hold,   1);
    check({tag, "_done"},       done,       0);
    check({tag, "_error"},      error,      0);
  endtask

  initial begin
    int w0;
    reset = 1'b0; start = 1'b0; byte_in = '0; byte_valid = 1'b0;

    // Reset with random activity on the inputs.
    repeat (2) begin
      start      = 1'($urandom_range(0, 1));
      byte_valid = 1'($urandom_range(0, 1));
      byte_in    = 8'($urandom);
      @(posedge clk); #1;
    end
    check_reset_values("rst");
    check("rst_rom_data", rom_data, 0);
    start = 1'b0; byte_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    // Basic two-word load with back-to-back bytes.
    expect_word(0, 16'h1234);
    expect_word(1, 16'hABCD);
    w0 = we_cycles.size();
    pulse_start();
    send(8'h00, 0); send(8'h02, 0);
    send(8'h12, 0); send(8'h34, 0);
    send(8'hAB, 0); send(8'hCD, 0);
    check("basic_last_we", rom_we, 1);
    check("basic_done_early", done, 0);
    @(posedge clk); #1;
    check("basic_done", done, 1);
    check("basic_cpu_hold", cpu_hold, 0);
    check("basic_we_count", we_cycles.size() - w0, 2);
    if (we_cycles.size() - w0 == 2)
      check("basic_we_spacing", we_cycles[w0+1] - we_cycles[w0], 3);

    // Zero-length image; start from DONE re-arms hold.
    w0 = we_cycles.size();
    pulse_start();
    check("restart_done_clr", done, 0);
    check("restart_hold", cpu_hold, 1);
    send(8'h00, 0); send(8'h00, 0);
    check("zero_done", done, 1);
    check("zero_cpu_hold", cpu_hold, 0);
    @(posedge clk); #1;
    check("zero_we_count", we_cycles.size() - w0, 0);

    // Stalled stream: valid pattern 1,0,0,1...
    expect_word(0, 16'h1234);
    expect_word(1, 16'hABCD);
    w0 = we_cycles.size();
    pulse_start();
    send(8'h00, 0); send(8'h02, 2);
    send(8'h12, 2); send(8'h34, 2);
    send(8'hAB, 2); send(8'hCD, 2);
    repeat (3) begin @(posedge clk); #1; end
    check("stall_done", done, 1);
    check("stall_we_count", we_cycles.size() - w0, 2);

    // Oversize header 0x8001, then recovery.
    w0 = we_cycles.size();
    pulse_start();
    send(8'h80, 0); send(8'h01, 0);
    check("over_error", error, 1);
    check("over_cpu_hold", cpu_hold, 1);
    check("over_ready", byte_ready, 0);
    repeat (2) begin @(posedge clk); #1; end
    check("over_error_sticky", error, 1);
    check("over_we_count", we_cycles.size() - w0, 0);
    expect_word(0, 16'h55AA);
    pulse_start();
    check("over_error_clr", error, 0);
    send(8'h00, 0); send(8'h01, 0);
    send(8'h55, 0); send(8'hAA, 0);
    @(posedge clk); #1;
    check("over_recover_done", done, 1);
    check("over_recover_error", error, 0);

    // Reset after the first of three words.
    expect_word(0, 16'h1111);
    pulse_start();
    send(8'h00, 0); send(8'h03, 0);
    send(8'h11, 0); send(8'h11, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_values("midrst");
    reset = 1'b1;
    @(posedge clk); #1;
    w0 = we_cycles.size();
    expect_word(0, 16'hA001);
    expect_word(1, 16'hB002);
    expect_word(2, 16'hC003);
    pulse_start();
    send(8'h00, 0); send(8'h03, 0);
    send(8'hA0, 0); send(8'h01, 0);
    send(8'hB0, 0); send(8'h02, 0);
    send(8'hC0, 0); send(8'h03, 0);
    @(posedge clk); #1;
    check("reload_done", done, 1);
    check("reload_cpu_hold", cpu_hold, 0);
    check("reload_we_count", we_cycles.size() - w0, 3);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
